// File: rtl/phvl_lut_loader.sv
// rtl/phvl_lut_loader.sv - stages a verified 64-word phase frame from the host stream and burst-writes it into one band's LUT
module phvl_lut_loader #(
  parameter logic [7:0] SYNC  = 8'hA5,
  parameter int         DEPTH = 64,
  parameter int         AW    = 6,
  parameter int         DW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [7:0]    s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          wr_en,
  output logic [1:0]    wr_band,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BAND   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CSUM   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [2:0]    state;
  logic [1:0]    band;
  logic [AW-1:0] cnt;
  logic [7:0]    csum_acc;
  logic          ovr;
  logic [DW-1:0] stage_mem [DEPTH];
  logic [AW-1:0] next_addr;
  logic          take;

  assign s_ready   = en && (state != S_COMMIT);
  assign take      = s_valid && s_ready;
  assign busy      = (state != S_IDLE);
  assign next_addr = wr_addr + 1'b1;

  // Staging buffer is not reset; only a fully verified frame is ever read out of it.
  always_ff @(posedge clk) begin
    if (state == S_DATA && take) begin
      stage_mem[cnt] <= s_data[DW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      band     <= 2'd0;
      cnt      <= '0;
      csum_acc <= 8'd0;
      ovr      <= 1'b0;
      wr_en    <= 1'b0;
      wr_band  <= 2'd0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (!en) begin
        // Abort silently; a half-finished commit is left as-is in the LUT.
        state <= S_IDLE;
        wr_en <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (take && s_data == SYNC) state <= S_BAND;
          end
          S_BAND: begin
            if (take) begin
              if (|s_data[7:2]) begin
                err      <= 1'b1;
                err_code <= 2'd1;
                state    <= S_IDLE;
              end else begin
                band     <= s_data[1:0];
                cnt      <= '0;
                csum_acc <= 8'd0;
                ovr      <= 1'b0;
                state    <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (take) begin
              csum_acc <= csum_acc ^ s_data;
              if (|s_data[7:DW]) ovr <= 1'b1;
              cnt <= cnt + 1'b1;
              if (cnt == LAST) state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (take) begin
              if (ovr) begin
                err      <= 1'b1;
                err_code <= 2'd2;
                state    <= S_IDLE;
              end else if (csum_acc != s_data) begin
                err      <= 1'b1;
                err_code <= 2'd3;
                state    <= S_IDLE;
              end else begin
                // First write is presented on the cycle right after the checksum byte.
                wr_en   <= 1'b1;
                wr_band <= band;
                wr_addr <= '0;
                wr_data <= stage_mem[0];
                state   <= S_COMMIT;
              end
            end
          end
          S_COMMIT: begin
            if (wr_addr == LAST) begin
              wr_en <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              wr_addr <= next_addr;
              wr_data <= stage_mem[next_addr];
            end
          end
          default: begin
            state <= S_IDLE;
            wr_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phvl_lut_loader.sv
// tb/tb_phvl_lut_loader.sv - scoreboard bench for phvl_lut_loader with randomized frames and gaps
module tb_phvl_lut_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       wr_en;
  logic [1:0] wr_band;
  logic [5:0] wr_addr;
  logic [4:0] wr_data;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  phvl_lut_loader dut (
    .clk(clk), .rst(rst), .en(en),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wr_en(wr_en), .wr_band(wr_band), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;   // 0 write, 1 done, 2 err
    logic [1:0] band;
    logic [5:0] addr;
    logic [4:0] data;
    logic [1:0] code;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] dat [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic push_ev(input int kind, input logic [1:0] band, input logic [5:0] addr,
                         input logic [4:0] data, input logic [1:0] code);
    ev_t e;
    e.kind = kind; e.band = band; e.addr = addr; e.data = data; e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    s_data  = b;
    s_valid = 1'b1;
    guard   = 0;
    while (!s_ready && guard < 200) begin @(posedge clk); #1; guard++; end
    if (guard >= 200) check("send_timeout", 1, 0);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  // Reference model: frame-level rules computed directly from the byte list.
  task automatic run_frame(input logic [7:0] band_b, input logic [7:0] cs_xor, input bit gaps);
    logic [7:0] x;
    bit         ovr;
    int         n;
    x = 8'd0; ovr = 0;
    for (int i = 0; i < 64; i++) begin
      x = x ^ dat[i];
      if (dat[i] > 8'd31) ovr = 1;
    end
    if (band_b > 8'd3) push_ev(2, 0, 0, 0, 2'd1);
    else if (ovr) push_ev(2, 0, 0, 0, 2'd2);
    else if (cs_xor != 8'd0) push_ev(2, 0, 0, 0, 2'd3);
    else begin
      for (int i = 0; i < 64; i++) push_ev(0, band_b[1:0], 6'(i), dat[i][4:0], 0);
      push_ev(1, 0, 0, 0, 0);
    end
    send_byte(8'hA5, gaps);
    send_byte(band_b, gaps);
    if (band_b > 8'd3) begin
      check("band_err_timing", {29'd0, err, err_code}, 32'h5);
      return;
    end
    for (int i = 0; i < 64; i++) send_byte(dat[i], gaps);
    send_byte(x ^ cs_xor, gaps);
    if (!ovr && cs_xor == 8'd0) begin
      n = 0;
      while (!s_ready && n < 200) begin @(posedge clk); #1; n++; end
      check("ready_low_cycles", n, 64);
      check("done_latency", done, 1);
    end else begin
      check("err_timing", err, 1);
    end
  endtask

  always @(negedge clk) begin
    if (rst && (wr_en || done || err)) begin
      check("done_err_exclusive", done & err, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_event", {wr_en, done, err}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        if (err) begin
          check("ev_kind_err", 2, mon_e.kind);
          check("err_code", err_code, mon_e.code);
        end else if (done) begin
          check("ev_kind_done", 1, mon_e.kind);
        end else begin
          check("ev_kind_write", 0, mon_e.kind);
          check("write", {wr_band, wr_addr, wr_data}, {mon_e.band, mon_e.addr, mon_e.data});
        end
      end
    end
  end

  initial begin
    int guard;
    logic [7:0] b;
    rst = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {s_ready, wr_en, wr_band, wr_addr, wr_data, busy, done, err, err_code}, 0);
    rst = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", {s_ready, busy}, 2'b10);

    for (int i = 0; i < 64; i++) dat[i] = 8'(i & 31);
    run_frame(8'h02, 8'h00, 0);
    run_frame(8'h02, 8'h01, 0);
    dat[5] = 8'h20;
    run_frame(8'h01, 8'h00, 0);
    dat[5] = 8'd5;
    run_frame(8'h04, 8'h00, 0);
    run_frame(8'h02, 8'h00, 0);

    send_byte(8'h00, 1); send_byte(8'hFF, 1); send_byte(8'h5A, 1);
    run_frame(8'h02, 8'h00, 1);

    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < 64; i++) dat[i] = 8'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) dat[$urandom_range(0, 63)] = 8'($urandom_range(32, 255));
      b = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      run_frame(b, ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 1);
    end

    // Disable mid-commit after write 10.
    for (int i = 0; i < 64; i++) dat[i] = 8'($urandom_range(0, 31));
    for (int i = 0; i <= 10; i++) push_ev(0, 2'd1, 6'(i), dat[i][4:0], 0);
    b = 8'd0;
    for (int i = 0; i < 64; i++) b = b ^ dat[i];
    send_byte(8'hA5, 0); send_byte(8'h01, 0);
    for (int i = 0; i < 64; i++) send_byte(dat[i], 0);
    send_byte(b, 0);
    guard = 0;
    while (!(wr_en && wr_addr == 6'd10) && guard < 100) begin @(posedge clk); #1; guard++; end
    check("abort_reach_write10", guard < 100, 1);
    en = 1'b0;
    @(posedge clk); #1;
    check("abort_state", {wr_en, busy, s_ready}, 0);
    en = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    check("abort_idle", {busy, s_ready, done}, 3'b010);

    // Reset in the middle of DATA.
    send_byte(8'hA5, 0); send_byte(8'h03, 0);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 31)), 0);
    check("busy_in_data", busy, 1);
    rst = 1'b0;
    #1;
    check("reset_mid_data", {wr_en, wr_band, wr_addr, wr_data, busy, done, err, err_code}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 64; i++) dat[i] = 8'($urandom_range(0, 31));
    run_frame(8'h03, 8'h00, 1);

    repeat (10) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
